// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM encoding and command word geometry.
package program_loader_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_BYTES = 3;
    localparam int CMD_W      = BYTE_W * WORD_BYTES;   // 24-bit command word
    localparam int OPC_HI     = CMD_W - 1;             // opcode lane [23:16]
    localparam int OPC_LO     = CMD_W - BYTE_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Big-endian byte-to-word shifter with byte counter and running XOR checksum.
module word_assembler #(
    parameter int BYTE_W     = program_loader_pkg::BYTE_W,
    parameter int WORD_BYTES = program_loader_pkg::WORD_BYTES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,        // start of a new load
    input  logic                         cnt_clr,    // word consumed, restart byte count
    input  logic                         shift_en,   // accepted data byte
    input  logic [BYTE_W-1:0]            byte_in,
    output logic [WORD_BYTES*BYTE_W-1:0] word,
    output logic [BYTE_W-1:0]            csum,
    output logic                         word_full   // this byte completes the word
);

    localparam int W     = WORD_BYTES * BYTE_W;
    localparam int CNT_W = $clog2(WORD_BYTES + 1);

    logic [CNT_W-1:0] cnt;

    assign word_full = shift_en && (cnt == CNT_W'(WORD_BYTES - 1));

    // First byte ends up in the top lane after WORD_BYTES shifts.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            word <= '0;
            csum <= '0;
            cnt  <= '0;
        end else begin
            if (shift_en) begin
                word <= {word[W-BYTE_W-1:0], byte_in};
                csum <= csum ^ byte_in;
            end
            if (cnt_clr)
                cnt <= '0;
            else if (shift_en)
                cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a byte stream into instruction memory as command words, verifies the
// trailing XOR checksum and holds the CPU in reset until a good image is in place.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int BYTE_W     = program_loader_pkg::BYTE_W,
    parameter int WORD_BYTES = program_loader_pkg::WORD_BYTES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            prog_len,
    input  logic                         byte_valid,
    input  logic [BYTE_W-1:0]            byte_data,
    output logic                         byte_ready,
    output logic                         mem_we,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [WORD_BYTES*BYTE_W-1:0] mem_wdata,
    output logic                         cpu_rst,
    output logic                         busy,
    output logic                         done,
    output logic                         error
);

    state_t            state, state_nxt;
    logic [ADDR_W:0]   len_q;      // one extra bit so prog_len=0 means 2**ADDR_W
    logic [ADDR_W:0]   word_cnt;
    logic [ADDR_W:0]   word_cnt_inc;
    logic [BYTE_W-1:0] csum;
    logic              word_full;
    logic              start_acc;
    logic              shift_en;
    logic              chk_xfer;

    assign start_acc    = start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign byte_ready   = (state == S_RECV) || (state == S_CHECK);
    assign shift_en     = byte_valid && (state == S_RECV);
    assign chk_xfer     = byte_valid && (state == S_CHECK);
    assign word_cnt_inc = word_cnt + (ADDR_W+1)'(1);

    word_assembler #(
        .BYTE_W     (BYTE_W),
        .WORD_BYTES (WORD_BYTES)
    ) u_asm (
        .clk       (clk),
        .rst       (rst),
        .clr       (start_acc),
        .cnt_clr   (state == S_WRITE),
        .shift_en  (shift_en),
        .byte_in   (byte_data),
        .word      (mem_wdata),
        .csum      (csum),
        .word_full (word_full)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Length latch plus write address and word counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q    <= '0;
            word_cnt <= '0;
            mem_addr <= '0;
        end else if (start_acc) begin
            len_q    <= (prog_len == '0) ? (ADDR_W+1)'(1 << ADDR_W) : {1'b0, prog_len};
            word_cnt <= '0;
            mem_addr <= '0;
        end else if (state == S_WRITE) begin
            word_cnt <= word_cnt_inc;
            mem_addr <= mem_addr + ADDR_W'(1);
        end
    end

    // Next state and state-decoded outputs; ERR keeps the CPU in reset.
    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        cpu_rst   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_acc) state_nxt = S_RECV;
            end
            S_RECV: begin
                cpu_rst = 1'b1;
                busy    = 1'b1;
                if (word_full) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                cpu_rst   = 1'b1;
                busy      = 1'b1;
                state_nxt = (word_cnt_inc == len_q) ? S_CHECK : S_RECV;
            end
            S_CHECK: begin
                cpu_rst = 1'b1;
                busy    = 1'b1;
                if (chk_xfer) state_nxt = (byte_data == csum) ? S_DONE : S_ERR;
            end
            S_DONE: begin
                done = 1'b1;
                if (start_acc) state_nxt = S_RECV;
            end
            S_ERR: begin
                cpu_rst = 1'b1;
                error   = 1'b1;
                if (start_acc) state_nxt = S_RECV;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected memory writes are queued as bytes
// are driven and popped by a monitor whenever mem_we is seen.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  prog_len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [23:0] mem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;

    typedef struct packed {
        logic [7:0]  addr;
        logic [23:0] data;
    } wr_t;

    wr_t q_exp[$];
    int  n_vec  = 0;
    int  n_bad  = 0;
    int  n_wr   = 0;
    bit  gaps   = 1'b0;

    program_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .prog_len   (prog_len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: every mem_we cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mem_we) begin
            n_wr++;
            chk("we_ready_low", {31'd0, byte_ready}, 32'd0);
            if (q_exp.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                wr_t e;
                e = q_exp.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                    chk("wr_addr", {24'd0, mem_addr}, {24'd0, e.addr});
                    chk("wr_data", {8'd0, mem_wdata}, {8'd0, e.data});
                end else begin
                    n_vec++;
                end
            end
        end
    end

    task automatic push(input int a, input logic [23:0] d);
        wr_t e;
        e.addr = 8'(a);
        e.data = d;
        q_exp.push_back(e);
    endtask

    task automatic do_start(input logic [7:0] len);
        start    = 1'b1;
        prog_len = len;
        @(posedge clk); #1;
        start    = 1'b0;
    endtask

    // Present one byte and hold it until the loader takes it.
    task automatic send(input logic [7:0] b);
        int n;
        if (gaps) begin
            int g;
            g = $urandom_range(0, 3);
            byte_valid = 1'b0;
            repeat (g) begin @(posedge clk); #1; end
        end
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("ready_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_basic(input logic [7:0] cs);
        logic [7:0] b;
        for (int i = 0; i < 6; i++) begin
            b = 8'(8'h11 * (i + 1));
            send(b);
        end
        send(cs);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (q_exp.size() != 0 && n < 50) begin @(posedge clk); #1; n++; end
        chk(tag, q_exp.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        rst = 1'b1; start = 1'b0; prog_len = '0; byte_valid = 1'b0; byte_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, error}, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic two-word load with a good checksum.
        w0 = n_wr;
        push(0, 24'h112233); push(1, 24'h445566);
        do_start(8'd2);
        chk("basic_busy", {busy, cpu_rst, done, error}, 4'b1100);
        send_basic(8'h77);
        drain("basic_drain");
        chk("basic_flags", {busy, cpu_rst, done, error}, 4'b0010);
        chk("basic_nwr", n_wr - w0, 2);

        // Same stream, bad checksum.
        w0 = n_wr;
        push(0, 24'h112233); push(1, 24'h445566);
        do_start(8'd2);
        chk("bad_clr_done", {done, error}, 2'b00);
        send_basic(8'h00);
        drain("bad_drain");
        chk("bad_flags", {busy, cpu_rst, done, error}, 4'b0101);
        chk("bad_nwr", n_wr - w0, 2);
        repeat (3) begin @(posedge clk); #1; end
        chk("err_sticky", {cpu_rst, error}, 2'b11);

        // One word with random gaps on byte_valid.
        w0 = n_wr;
        gaps = 1'b1;
        push(0, 24'hA1B2C3);
        do_start(8'd1);
        send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD0);
        gaps = 1'b0;
        drain("gap_drain");
        chk("gap_flags", {busy, cpu_rst, done, error}, 4'b0010);
        chk("gap_nwr", n_wr - w0, 1);

        // prog_len=0 loads 256 words and the address wraps back to 0.
        w0 = n_wr;
        for (int i = 0; i < 256; i++) push(i, 24'h010101);
        do_start(8'd0);
        for (int i = 0; i < 768; i++) send(8'h01);
        send(8'h00);
        drain("wrap_drain");
        chk("wrap_nwr", n_wr - w0, 256);
        chk("wrap_addr", {24'd0, mem_addr}, 32'd0);
        chk("wrap_flags", {busy, cpu_rst, done, error}, 4'b0010);

        // Reset after 4 of 6 bytes: first word already written, partial discarded.
        push(0, 24'h112233);
        do_start(8'd2);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        drain("rstmid_drain");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rstmid_outputs", {byte_ready, mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, error}, '0);
        w0 = n_wr;
        push(0, 24'hABCDEF);
        do_start(8'd1);
        send(8'hAB); send(8'hCD); send(8'hEF); send(8'h89);
        drain("postrst_drain");
        chk("postrst_flags", {busy, cpu_rst, done, error}, 4'b0010);
        chk("postrst_nwr", n_wr - w0, 1);

        // start while receiving must not restart or relatch the length.
        w0 = n_wr;
        push(0, 24'h112233); push(1, 24'h445566);
        do_start(8'd2);
        send(8'h11); send(8'h22);
        do_start(8'd5);
        chk("busy_ignore", {busy, cpu_rst}, 2'b11);
        send(8'h33); send(8'h44); send(8'h55); send(8'h66); send(8'h77);
        drain("busy_drain");
        chk("busy_flags", {busy, cpu_rst, done, error}, 4'b0010);
        chk("busy_nwr", n_wr - w0, 2);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Writer-side counterpart to the processor's instruction fetch path. It accepts a byte stream over a valid/ready handshake and assembles 24-bit command words, big-endian. It writes the words into instruction memory from address 0 and verifies a trailing XOR checksum. While loading, it holds the processor in reset, then releases it so fetch starts from the new program.

Parameters:
ADDR_W, 8, instruction memory address width (matches 8-bit PC)
BYTE_W, 8, width of incoming stream bytes
WORD_BYTES, 3, bytes per command word (24-bit command word)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a load; ignored unless in IDLE, DONE or ERR
prog_len  input  ADDR_W  number of words to load; sampled on accepted start; 0 means 256
byte_valid  input  1  upstream byte present
byte_data  input  BYTE_W  upstream byte
byte_ready  output  1  loader accepts a byte this cycle
mem_we  output  1  instruction memory write enable, one cycle per word
mem_addr  output  ADDR_W  write address
mem_wdata  output  WORD_BYTES*BYTE_W  assembled command word
cpu_rst  output  1  processor reset hold
busy  output  1  load in progress
done  output  1  load finished with checksum OK (sticky)
error  output  1  checksum mismatch (sticky)

Behaviour:
- Reset values: state=IDLE; byte_ready=0; mem_we=0; mem_addr=0; mem_wdata=0; cpu_rst=0; busy=0; done=0; error=0. Internal values: byte count=0, word count=0, checksum=0.
- A byte transfer happens on a rising edge where byte_valid && byte_ready. byte_ready is combinational from state: it is 1 only in RECV and CHECK.
- IDLE/DONE/ERR + start -> RECV on the next edge. On that edge:
  - latch prog_len;
  - clear mem_addr, the counters and the checksum;
  - clear done and error;
  - set cpu_rst=1 and busy=1.
- RECV: each transfer shifts the byte in. The first byte lands in bits [23:16] (opcode), the last in [7:0]. The byte is XORed into the checksum. When the WORD_BYTES-th byte transfers -> WRITE.
- WRITE: exactly one cycle.
  - mem_we=1, with mem_addr and mem_wdata stable; byte_ready=0.
  - Latency: third byte accepted at edge N -> mem_we high during cycle N..N+1.
  - On exit, mem_addr increments and the byte count clears.
  - If the word count equals the latched length -> CHECK, else -> RECV.
- CHECK: on one byte transfer, compare the byte with the checksum (XOR of all 3*len data bytes).
  - Equal -> DONE.
  - Unequal -> ERR.
- DONE: cpu_rst=0, busy=0, done=1 held until the next accepted start or rst.
- ERR: cpu_rst stays 1 (processor never runs a corrupt image), busy=0, error=1 held until the next accepted start or rst.
- Word count: for prog_len=0, 256 words load and mem_addr wraps 255->0 after the last write. The length comparison uses an ADDR_W+1-bit counter.
- start while in RECV/WRITE/CHECK is ignored. byte_valid outside RECV/CHECK is not consumed.
- rst mid-load: next state IDLE with all reset values, including cpu_rst=0. The partial word is discarded. Memory contents already written are not rolled back.
- byte_valid gaps in RECV stall indefinitely; there is no timeout.

Decomposition:
- Shared package holds:
  - state encoding IDLE/RECV/WRITE/CHECK/DONE/ERR;
  - WORD_BYTES and BYTE_W;
  - command word width 24;
  - opcode lane constant [23:16].
- One sub-module is natural: word_assembler (shift register, byte counter, running XOR, word_full flag). The FSM, address and word counters stay in program_loader.

Test Plan:
- Basic load: prog_len=2, bytes 0x11 0x22 0x33 0x44 0x55 0x66, checksum 0x77 ->
  - writes 0x112233 @0 and 0x445566 @1, one mem_we cycle each;
  - done=1, cpu_rst falls to 0, error=0.
- Bad checksum: same stream with 0x00 as the final byte -> both words written, error=1, cpu_rst stays 1, done=0.
- Backpressure/gaps: byte_valid toggled randomly on a 1-word load (0xA1 0xB2 0xC3, checksum 0xD0) ->
  - no byte dropped or duplicated;
  - byte_ready=0 during the WRITE cycle;
  - mem_wdata=0xA1B2C3 @0.
- Full wrap: prog_len=0, 768 bytes of 0x01 plus checksum 0x00 -> 256 writes at addresses 0..255, mem_addr ends at 0, done=1.
- Reset mid-load: rst asserted after 4 of 6 bytes -> next cycle all outputs at reset values. A subsequent 1-word load writes to address 0.
- Start while busy: start pulsed in RECV with a different prog_len -> ignored; the original length completes and is verified.
